accel_ctrl: RTL

ACCEL_CTRL -- requirements
Module: accel_ctrl

---
 rtl/accel_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/accel_ctrl.sv
// rtl/accel_ctrl.sv - frame buffer controller: receive frame, run engine, stream results
// Header word selects FFT/FIR/passthrough; the buffer is shared with the engine for in-place compute.
module accel_ctrl #(
    parameter int DW      = 16,
    parameter int DEPTH   = 128,
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic [DW-1:0]            data_in,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    output logic [DW-1:0]            data_out,
    output logic                     data_out_valid,
    input  logic                     data_out_ready,
    output logic                     eng_start,
    output logic [1:0]               eng_mode,
    output logic [7:0]               eng_len,
    input  logic                     eng_done,
    input  logic [$clog2(DEPTH)-1:0] eng_rd_addr,
    output logic [DW-1:0]            eng_rd_data,
    input  logic                     eng_wr_en,
    input  logic [$clog2(DEPTH)-1:0] eng_wr_addr,
    input  logic [DW-1:0]            eng_wr_data,
    output logic                     core_busy,
    output logic                     err,
    output logic [1:0]               err_code
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_START, S_COMPUTE, S_XMIT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_tmo;
    logic [1:0]      r_mode;
    logic [7:0]      r_len;
    logic [DW-1:0]   r_dout;
    logic            r_dout_valid;
    logic [1:0]      r_err_code;

    logic            w_in_ready;
    logic            w_in_fire;
    logic            w_start;
    logic            w_err;
    logic [1:0]      w_err_code;
    logic            w_hdr_ok;
    logic            w_cnt_last;
    logic            w_tmo_hit;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [DW-1:0]   w_mem_wdata;
    logic [AW-1:0]   w_rd_next;

    assign w_in_fire  = data_in_valid & w_in_ready;
    assign w_cnt_last = (32'(r_cnt) == {24'd0, r_len});
    assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
    assign w_rd_next  = r_cnt[AW-1:0] + AW'(1);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_start     = 1'b0;
        w_err       = 1'b0;
        w_err_code  = r_err_code;
        w_hdr_ok    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_cnt[AW-1:0];
        w_mem_wdata = data_in;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (data_in_valid) begin
                    // Mode check outranks the length check when both are bad.
                    if (data_in[1:0] == 2'b11) begin
                        w_err      = 1'b1;
                        w_err_code = 2'b01;
                    end else if ({24'd0, data_in[9:2]} >= 32'(DEPTH)) begin
                        w_err      = 1'b1;
                        w_err_code = 2'b10;
                    end else begin
                        w_hdr_ok = 1'b1;
                        w_next   = S_RECV;
                    end
                end
            end
            S_RECV: begin
                w_in_ready = 1'b1;
                if (data_in_valid) begin
                    w_mem_we = 1'b1;
                    if (w_cnt_last) begin
                        w_next = (r_mode == 2'b10) ? S_XMIT : S_START;
                    end
                end
            end
            S_START: begin
                w_start = 1'b1;
                w_next  = S_COMPUTE;
            end
            S_COMPUTE: begin
                w_mem_we    = eng_wr_en;
                w_mem_addr  = eng_wr_addr;
                w_mem_wdata = eng_wr_data;
                if (eng_done) begin
                    w_next = S_XMIT;
                end else if (w_tmo_hit) begin
                    w_err      = 1'b1;
                    w_err_code = 2'b11;
                    w_next     = S_IDLE;
                end
            end
            S_XMIT: begin
                if (r_dout_valid && data_out_ready && w_cnt_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_mode       <= '0;
            r_len        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_err_code   <= '0;
        end else begin
            r_err_code <= w_err_code;
            case (r_state)
                S_IDLE: begin
                    if (w_hdr_ok) begin
                        r_mode <= data_in[1:0];
                        r_len  <= data_in[9:2];
                        r_cnt  <= '0;
                    end
                end
                S_RECV: begin
                    if (w_in_fire) begin
                        r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
                    end
                end
                S_START: r_tmo <= '0;
                S_COMPUTE: begin
                    r_tmo <= r_tmo + TW'(1);
                    if (eng_done) begin
                        r_cnt <= '0;
                    end
                end
                S_XMIT: begin
                    // First XMIT cycle only loads word 0, so engine write-backs landing with eng_done are seen.
                    if (!r_dout_valid) begin
                        r_dout       <= r_mem[r_cnt[AW-1:0]];
                        r_dout_valid <= 1'b1;
                    end else if (data_out_ready) begin
                        if (w_cnt_last) begin
                            r_dout_valid <= 1'b0;
                        end else begin
                            r_cnt  <= r_cnt + CW'(1);
                            r_dout <= r_mem[w_rd_next];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_in_ready  = w_in_ready;
    assign data_out       = r_dout;
    assign data_out_valid = r_dout_valid;
    assign eng_start      = w_start;
    assign eng_mode       = r_mode;
    assign eng_len        = r_len;
    assign eng_rd_data    = r_mem[eng_rd_addr];
    assign core_busy      = (r_state != S_IDLE);
    assign err            = w_err;
    assign err_code       = w_err_code;

endmodule
